// File: rtl/mem_arbiter_pkg.sv
// Shared declarations for the board-memory arbiter: FSM state encoding,
// owner codes and datapath widths.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_VID  = 2'd2;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int LAT_W  = 2;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Grant decision for the shared memory port: VID wins by default, and the CPU
// is forced through after STARVE consecutive VID grants while it waits.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE = 4
)
(
    input  logic clock,
    input  logic reset_n,
    input  logic cpu_req,
    input  logic vid_req,
    input  logic idle,
    output logic gnt_cpu,
    output logic gnt_vid
);

    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE);

    logic [CNT_W-1:0] r_cnt;
    logic             w_cpu_forced;

    assign w_cpu_forced = cpu_req && (r_cnt == STARVE_C);
    assign gnt_vid      = idle && vid_req && !w_cpu_forced;
    assign gnt_cpu      = idle && cpu_req && !gnt_vid;

    // Counter only moves in IDLE; a CPU that stops asking forfeits its credit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (idle) begin
            if (!cpu_req || gnt_cpu) begin
                r_cnt <= '0;
            end else if (gnt_vid && (r_cnt < STARVE_C)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the 20-bit/8-bit board memory port between the CPU and the video fetcher.
//   state  | meaning
//   IDLE   | sample requests, grant one and latch address/data/we
//   ACCESS | wait out read latency (writes last one cycle)
//   DONE   | ack pulse to the owner, requests ignored
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int STARVE = 4
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_address,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_o_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_i_data,
    output logic [1:0]        owner
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    arb_state_t        r_state;
    logic [LAT_W-1:0]  r_lat;
    logic              r_is_wr;
    logic [1:0]        r_owner;
    logic              r_cpu_ack;
    logic              r_vid_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_vid_rdata;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_o_data;
    logic              r_mem_we;

    logic w_idle;
    logic w_gnt_cpu;
    logic w_gnt_vid;

    assign w_idle = (r_state == ST_IDLE);

    mem_arb_prio #(
        .STARVE (STARVE)
    ) u_prio (
        .clock   (clock),
        .reset_n (reset_n),
        .cpu_req (cpu_req),
        .vid_req (vid_req),
        .idle    (w_idle),
        .gnt_cpu (w_gnt_cpu),
        .gnt_vid (w_gnt_vid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_lat         <= '0;
            r_is_wr       <= 1'b0;
            r_owner       <= OWN_NONE;
            r_cpu_ack     <= 1'b0;
            r_vid_ack     <= 1'b0;
            r_cpu_rdata   <= '0;
            r_vid_rdata   <= '0;
            r_mem_address <= '0;
            r_mem_o_data  <= '0;
            r_mem_we      <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_vid_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_cpu) begin
                        r_mem_address <= cpu_address;
                        r_mem_o_data  <= cpu_wdata;
                        r_mem_we      <= cpu_we;
                        r_is_wr       <= cpu_we;
                        r_owner       <= OWN_CPU;
                        r_lat         <= LAT_LOAD;
                        r_state       <= ST_ACCESS;
                    end else if (w_gnt_vid) begin
                        r_mem_address <= vid_address;
                        r_mem_o_data  <= '0;
                        r_mem_we      <= 1'b0;
                        r_is_wr       <= 1'b0;
                        r_owner       <= OWN_VID;
                        r_lat         <= LAT_LOAD;
                        r_state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Writes complete after one cycle regardless of read latency.
                    if (r_is_wr || (r_lat == '0)) begin
                        r_mem_we <= 1'b0;
                        r_state  <= ST_DONE;
                        if (r_owner == OWN_CPU) begin
                            r_cpu_ack <= 1'b1;
                            if (!r_is_wr) begin
                                r_cpu_rdata <= mem_i_data;
                            end
                        end else begin
                            r_vid_ack   <= 1'b1;
                            r_vid_rdata <= mem_i_data;
                        end
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_owner <= OWN_NONE;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = r_cpu_rdata;
    assign vid_ack     = r_vid_ack;
    assign vid_rdata   = r_vid_rdata;
    assign mem_address = r_mem_address;
    assign mem_o_data  = r_mem_o_data;
    assign mem_we      = r_mem_we;
    assign owner       = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model checked every cycle, plus
// hand-computed literal expectations scheduled by cycle number.
module tb_mem_arbiter;

    localparam int RD_LAT = 3;
    localparam int STARVE = 4;

    localparam int F_CPU_ACK = 0;
    localparam int F_VID_ACK = 1;
    localparam int F_OWNER   = 2;
    localparam int F_WE      = 3;
    localparam int F_ADDR    = 4;
    localparam int F_ODATA   = 5;
    localparam int F_CPU_RD  = 6;
    localparam int F_VID_RD  = 7;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [19:0] cpu_address = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        vid_req = 1'b0;
    logic [19:0] vid_address = '0;
    logic [7:0]  mem_i_data = '0;
    logic        cpu_ack;
    logic        vid_ack;
    logic        mem_we;
    logic [7:0]  cpu_rdata;
    logic [7:0]  vid_rdata;
    logic [7:0]  mem_o_data;
    logic [19:0] mem_address;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] tb_ram  [0:1048575];
    logic [7:0] mdl_ram [0:1048575];

    typedef struct {
        int          cyc;
        int          fld;
        logic [19:0] val;
    } lit_t;
    lit_t lits[$];

    mem_arbiter #(
        .RD_LAT (RD_LAT),
        .STARVE (STARVE)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_ack     (vid_ack),
        .vid_rdata   (vid_rdata),
        .mem_address (mem_address),
        .mem_o_data  (mem_o_data),
        .mem_we      (mem_we),
        .mem_i_data  (mem_i_data),
        .owner       (owner)
    );

    always #5 clock = ~clock;

    // Asynchronous-read RAM behind the DUT.
    always @(posedge clock) begin
        if (mem_we) tb_ram[mem_address] = mem_o_data;
        #1 mem_i_data = tb_ram[mem_address];
    end

    // Behavioural model: each grant opens a transaction of length L (1 for a
    // write, RD_LAT for a read); ack at grant+L, owner released at grant+L+1,
    // next grant possible at grant+L+2.
    int          free_at = 0;
    int          g_edge = 0;
    int          g_lat = 1;
    bit          g_act = 0;
    logic [1:0]  g_own = 2'd0;
    logic [19:0] g_addr = '0;
    logic        g_we = 1'b0;
    logic [7:0]  g_wd = '0;
    int          cnt = 0;
    logic        e_cpu_ack = 1'b0;
    logic        e_vid_ack = 1'b0;
    logic        e_we = 1'b0;
    logic [1:0]  e_owner = 2'd0;
    logic [19:0] e_addr = '0;
    logic [7:0]  e_odata = '0;
    logic [7:0]  e_cpu_rd = '0;
    logic [7:0]  e_vid_rd = '0;

    task automatic start_tx(input logic [1:0] who, input logic [19:0] a,
                            input logic we, input logic [7:0] wd);
        g_act   = 1;
        g_edge  = cyc;
        g_own   = who;
        g_addr  = a;
        g_we    = we;
        g_wd    = wd;
        g_lat   = we ? 1 : RD_LAT;
        free_at = cyc + g_lat + 2;
        e_owner = who;
        e_addr  = a;
        e_we    = we;
        if (we) e_odata = wd;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            g_act = 0;
            free_at = 0;
            cnt = 0;
            e_cpu_ack = 1'b0;
            e_vid_ack = 1'b0;
            e_we = 1'b0;
            e_owner = 2'd0;
            e_addr = '0;
            e_odata = '0;
            e_cpu_rd = '0;
            e_vid_rd = '0;
        end else begin
            cyc++;
            e_cpu_ack = 1'b0;
            e_vid_ack = 1'b0;
            e_we = 1'b0;
            if (g_act) begin
                if (g_we && cyc == g_edge + 1) mdl_ram[g_addr] = g_wd;
                if (cyc == g_edge + g_lat) begin
                    if (g_own == 2'd1) begin
                        e_cpu_ack = 1'b1;
                        if (!g_we) e_cpu_rd = mdl_ram[g_addr];
                    end else begin
                        e_vid_ack = 1'b1;
                        e_vid_rd = mdl_ram[g_addr];
                    end
                end
                if (cyc == g_edge + g_lat + 1) begin
                    g_act = 0;
                    e_owner = 2'd0;
                end
            end
            if (!g_act && cyc >= free_at) begin
                if (cpu_req && (!vid_req || cnt == STARVE)) begin
                    start_tx(2'd1, cpu_address, cpu_we, cpu_wdata);
                    cnt = 0;
                end else if (vid_req) begin
                    start_tx(2'd2, vid_address, 1'b0, 8'h00);
                    cnt = !cpu_req ? 0 : ((cnt < STARVE) ? cnt + 1 : cnt);
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic string lit_name(input int f);
        case (f)
            F_CPU_ACK: return "lit_cpu_ack";
            F_VID_ACK: return "lit_vid_ack";
            F_OWNER:   return "lit_owner";
            F_WE:      return "lit_mem_we";
            F_ADDR:    return "lit_mem_address";
            F_ODATA:   return "lit_mem_o_data";
            F_CPU_RD:  return "lit_cpu_rdata";
            default:   return "lit_vid_rdata";
        endcase
    endfunction

    function automatic logic [19:0] dut_field(input int f);
        case (f)
            F_CPU_ACK: return 20'(cpu_ack);
            F_VID_ACK: return 20'(vid_ack);
            F_OWNER:   return 20'(owner);
            F_WE:      return 20'(mem_we);
            F_ADDR:    return mem_address;
            F_ODATA:   return 20'(mem_o_data);
            F_CPU_RD:  return 20'(cpu_rdata);
            default:   return 20'(vid_rdata);
        endcase
    endfunction

    always @(negedge clock) begin
        chk("cpu_ack", 20'(cpu_ack), 20'(e_cpu_ack));
        chk("vid_ack", 20'(vid_ack), 20'(e_vid_ack));
        chk("owner", 20'(owner), 20'(e_owner));
        chk("mem_we", 20'(mem_we), 20'(e_we));
        chk("mem_address", mem_address, e_addr);
        chk("cpu_rdata", 20'(cpu_rdata), 20'(e_cpu_rd));
        chk("vid_rdata", 20'(vid_rdata), 20'(e_vid_rd));
        if (e_we) chk("mem_o_data", 20'(mem_o_data), 20'(e_odata));
        for (int i = lits.size() - 1; i >= 0; i--) begin
            if (lits[i].cyc == cyc) begin
                chk(lit_name(lits[i].fld), dut_field(lits[i].fld), lits[i].val);
                lits.delete(i);
            end
        end
    end

    task automatic lit(input int c, input int f, input logic [19:0] v);
        lit_t l;
        l.cyc = c;
        l.fld = f;
        l.val = v;
        lits.push_back(l);
    endtask

    task automatic new_cpu();
        cpu_we      = ($urandom_range(0, 2) == 0);
        cpu_address = 20'h00400 + 20'($urandom_range(0, 15));
        cpu_wdata   = 8'($urandom);
    endtask

    task automatic new_vid();
        vid_address = 20'h00400 + 20'($urandom_range(0, 15));
    endtask

    function automatic logic [7:0] pat(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]};
    endfunction

    int n;
    int c;
    int sv;

    initial begin
        for (int i = 0; i < 1048576; i++) begin
            tb_ram[i]  = pat(20'(i));
            mdl_ram[i] = pat(20'(i));
        end
        tb_ram[20'h12345] = 8'hA5;  mdl_ram[20'h12345] = 8'hA5;
        tb_ram[20'h0ABCD] = 8'h5E;  mdl_ram[20'h0ABCD] = 8'h5E;
        tb_ram[20'h0ABCE] = 8'h77;  mdl_ram[20'h0ABCE] = 8'h77;
        tb_ram[20'h00777] = 8'h11;  mdl_ram[20'h00777] = 8'h11;

        // Reset state.
        lit(0, F_OWNER, 20'h0);
        lit(0, F_WE, 20'h0);
        lit(0, F_CPU_ACK, 20'h0);
        lit(0, F_VID_ACK, 20'h0);
        lit(0, F_ADDR, 20'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Isolated CPU read of 0x12345.
        n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h12345;
        lit(n + 1, F_ADDR, 20'h12345);
        lit(n + 1, F_OWNER, 20'd1);
        lit(n + 3, F_CPU_ACK, 20'd0);
        lit(n + 4, F_CPU_ACK, 20'd1);
        lit(n + 4, F_CPU_RD, 20'hA5);
        lit(n + 5, F_CPU_ACK, 20'd0);
        lit(n + 5, F_OWNER, 20'd0);
        repeat (4) @(negedge clock);
        cpu_req = 1'b0;
        repeat (2) @(negedge clock);

        // CPU write 0x3C to 0x00400, then read it back.
        n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 20'h00400; cpu_wdata = 8'h3C;
        lit(n + 1, F_WE, 20'd1);
        lit(n + 1, F_ODATA, 20'h3C);
        lit(n + 2, F_WE, 20'd0);
        lit(n + 2, F_CPU_ACK, 20'd1);
        lit(n + 3, F_CPU_ACK, 20'd0);
        repeat (2) @(negedge clock);
        cpu_req = 1'b0;
        repeat (2) @(negedge clock);

        // CPU read held across ack with a new address: no double service.
        n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h00400;
        lit(n + 4, F_CPU_RD, 20'h3C);
        lit(n + 5, F_OWNER, 20'd0);
        lit(n + 5, F_ADDR, 20'h00400);
        lit(n + 6, F_OWNER, 20'd1);
        lit(n + 6, F_ADDR, 20'h12345);
        lit(n + 9, F_CPU_ACK, 20'd1);
        lit(n + 9, F_CPU_RD, 20'hA5);
        repeat (4) @(negedge clock);
        cpu_address = 20'h12345;
        repeat (5) @(negedge clock);
        cpu_req = 1'b0;
        repeat (2) @(negedge clock);

        // VID back-to-back reads: spacing RD_LAT+2.
        n = cyc;
        vid_req = 1'b1; vid_address = 20'h0ABCD;
        lit(n + 4, F_VID_ACK, 20'd1);
        lit(n + 4, F_VID_RD, 20'h5E);
        lit(n + 5, F_ADDR, 20'h0ABCD);
        lit(n + 6, F_ADDR, 20'h0ABCE);
        lit(n + 6, F_OWNER, 20'd2);
        lit(n + 9, F_VID_ACK, 20'd1);
        lit(n + 9, F_VID_RD, 20'h77);
        repeat (4) @(negedge clock);
        vid_address = 20'h0ABCE;
        repeat (5) @(negedge clock);
        vid_req = 1'b0;
        repeat (2) @(negedge clock);

        // Both held: VID x4 then CPU forced through.
        n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h12345;
        vid_req = 1'b1; vid_address = 20'h0ABCD;
        for (int k = 0; k < 10; k++) begin
            lit(n + 1 + 5 * k, F_OWNER, (k % 5 == 4) ? 20'd1 : 20'd2);
        end
        lit(n + 4, F_VID_ACK, 20'd1);
        lit(n + 24, F_CPU_ACK, 20'd1);
        repeat (49) @(negedge clock);
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (3) @(negedge clock);

        // Reset pulsed during a CPU write access.
        n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 20'h00777; cpu_wdata = 8'h55;
        lit(n + 1, F_WE, 20'd0);
        lit(n + 1, F_CPU_ACK, 20'd0);
        lit(n + 1, F_OWNER, 20'd0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        @(negedge clock);
        cpu_req = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        c = cyc;
        lit(c + 1, F_CPU_ACK, 20'd0);
        lit(c + 1, F_OWNER, 20'd0);
        lit(c + 2, F_CPU_ACK, 20'd0);
        repeat (2) @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h00777;
        lit(c + 3, F_OWNER, 20'd1);
        lit(c + 6, F_CPU_ACK, 20'd1);
        lit(c + 6, F_CPU_RD, 20'h11);
        repeat (4) @(negedge clock);
        cpu_req = 1'b0;
        repeat (2) @(negedge clock);

        // Randomised traffic against the model.
        sv = $urandom(32'h1234);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (cpu_req && cpu_ack) begin
                cpu_req = ($urandom_range(0, 1) == 1);
                if (cpu_req) new_cpu();
            end else if (!cpu_req && $urandom_range(0, 3) != 0) begin
                cpu_req = 1'b1;
                new_cpu();
            end
            if (vid_req && vid_ack) begin
                vid_req = ($urandom_range(0, 1) == 1);
                if (vid_req) new_vid();
            end else if (!vid_req && $urandom_range(0, 3) != 0) begin
                vid_req = 1'b1;
                new_vid();
            end
        end
        @(negedge clock);
        cpu_req = 1'b0;
        vid_req = 1'b0;
        repeat (10) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
